// File: rtl/s_aes_pkg.sv
// Shared S-AES definitions: FSM state encoding, round constants and GF(2^4) / S-box helpers.
package s_aes_pkg;

  typedef enum logic [2:0] {IDLE, KEY, RND2, RND1, FIN, DONE} state_t;

  localparam logic [7:0] RCON1   = 8'h80;
  localparam logic [7:0] RCON2   = 8'h30;
  localparam logic [4:0] GF_POLY = 5'b10011;

  function automatic logic [3:0] gf_mul2(input logic [3:0] a);
    logic [4:0] t;
    t = {a, 1'b0};
    if (t[4]) t = t ^ GF_POLY;
    return t[3:0];
  endfunction

  function automatic logic [3:0] gf_mul9(input logic [3:0] a);
    return gf_mul2(gf_mul2(gf_mul2(a))) ^ a;
  endfunction

  function automatic logic [3:0] sbox(input logic [3:0] a);
    case (a)
      4'h0: return 4'h9;  4'h1: return 4'h4;  4'h2: return 4'hA;  4'h3: return 4'hB;
      4'h4: return 4'hD;  4'h5: return 4'h1;  4'h6: return 4'h8;  4'h7: return 4'h5;
      4'h8: return 4'h6;  4'h9: return 4'h2;  4'hA: return 4'h0;  4'hB: return 4'h3;
      4'hC: return 4'hC;  4'hD: return 4'hE;  4'hE: return 4'hF;  default: return 4'h7;
    endcase
  endfunction

  function automatic logic [3:0] inv_sbox(input logic [3:0] a);
    case (a)
      4'h0: return 4'hA;  4'h1: return 4'h5;  4'h2: return 4'h9;  4'h3: return 4'hB;
      4'h4: return 4'h1;  4'h5: return 4'h7;  4'h6: return 4'h8;  4'h7: return 4'hF;
      4'h8: return 4'h6;  4'h9: return 4'h0;  4'hA: return 4'h2;  4'hB: return 4'h3;
      4'hC: return 4'hC;  4'hD: return 4'h4;  4'hE: return 4'hD;  default: return 4'hE;
    endcase
  endfunction

  function automatic logic [7:0] rot_nib(input logic [7:0] b);
    return {b[3:0], b[7:4]};
  endfunction

endpackage

// File: rtl/s_aes_decryptor_inv_mix_columns.sv
// Combinational S-AES InvMixColumns: per column a' = 9a ^ 2b, b' = 2a ^ 9b over GF(2^4).
module inv_mix_columns
  import s_aes_pkg::*;
(
  input  logic [15:0] in_state,
  output logic [15:0] out_state
);

  for (genvar c = 0; c < 2; c++) begin : g_col
    logic [3:0] a, b;
    assign a = in_state[15-8*c -: 4];
    assign b = in_state[11-8*c -: 4];
    assign out_state[15-8*c -: 4] = gf_mul9(a) ^ gf_mul2(b);
    assign out_state[11-8*c -: 4] = gf_mul2(a) ^ gf_mul9(b);
  end

endmodule

// File: rtl/s_aes_decryptor.sv
// Iterative S-AES decryptor: key expansion, two inverse rounds and final whitening, one step per cycle.
module s_aes_decryptor
  import s_aes_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] cipher_in,
  input  logic [15:0] key_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] plain_out,
  output logic        busy
);

  state_t      st;
  logic [15:0] s, key, k1, k2;

  function automatic logic [7:0] sub_nib8(input logic [7:0] b);
    return {sbox(b[7:4]), sbox(b[3:0])};
  endfunction

  function automatic logic [15:0] inv_sub16(input logic [15:0] x);
    return {inv_sbox(x[15:12]), inv_sbox(x[11:8]), inv_sbox(x[7:4]), inv_sbox(x[3:0])};
  endfunction

  // Swapping the bottom-row nibbles is its own inverse.
  function automatic logic [15:0] inv_shift(input logic [15:0] x);
    return {x[15:12], x[3:0], x[7:4], x[11:8]};
  endfunction

  logic [7:0]  w2, w3, w4, w5;
  assign w2 = key[15:8] ^ RCON1 ^ sub_nib8(rot_nib(key[7:0]));
  assign w3 = w2 ^ key[7:0];
  assign w4 = w2 ^ RCON2 ^ sub_nib8(rot_nib(w3));
  assign w5 = w4 ^ w3;

  logic [15:0] imc_in, imc_out, rnd2_nxt, rnd1_nxt;
  assign rnd2_nxt = inv_sub16(inv_shift(s ^ k2));
  assign imc_in   = s ^ k1;
  assign rnd1_nxt = inv_sub16(inv_shift(imc_out));

  inv_mix_columns u_imc (
    .in_state  (imc_in),
    .out_state (imc_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= IDLE;
      s         <= '0;
      key       <= '0;
      k1        <= '0;
      k2        <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      plain_out <= '0;
    end else begin
      case (st)
        IDLE: if (in_valid) begin
          s        <= cipher_in;
          key      <= key_in;
          in_ready <= 1'b0;
          busy     <= 1'b1;
          st       <= KEY;
        end
        KEY: begin
          k1 <= {w2, w3};
          k2 <= {w4, w5};
          st <= RND2;
        end
        RND2: begin
          s  <= rnd2_nxt;
          st <= RND1;
        end
        RND1: begin
          s  <= rnd1_nxt;
          st <= FIN;
        end
        FIN: begin
          s         <= s ^ key;
          plain_out <= s ^ key;
          out_valid <= 1'b1;
          st        <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          plain_out <= '0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          st        <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_s_aes_decryptor.sv
// Self-checking bench for s_aes_decryptor: known vectors, stalls, busy input, reset abort, random round trips.
module tb_s_aes_decryptor;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready;
  logic [15:0] cipher_in, key_in;
  logic        in_ready, out_valid, busy;
  logic [15:0] plain_out;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  s_aes_decryptor dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .cipher_in (cipher_in),
    .key_in    (key_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .plain_out (plain_out),
    .busy      (busy)
  );

  // Reference S-AES encryption: table S-box, shift-and-add GF(2^4) multiply.
  localparam logic [3:0] SB [16] = '{4'h9, 4'h4, 4'hA, 4'hB, 4'hD, 4'h1, 4'h8, 4'h5,
                                     4'h6, 4'h2, 4'h0, 4'h3, 4'hC, 4'hE, 4'hF, 4'h7};

  function automatic logic [3:0] gmul(input logic [3:0] a, input logic [3:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 4; i++) if (b[i]) p = p ^ (8'(a) << i);
    for (int i = 7; i >= 4; i--) if (p[i]) p = p ^ (8'h13 << (i - 4));
    return p[3:0];
  endfunction

  function automatic logic [7:0] sub8(input logic [7:0] x);
    return {SB[x[7:4]], SB[x[3:0]]};
  endfunction

  function automatic logic [15:0] sub16(input logic [15:0] x);
    return {sub8(x[15:8]), sub8(x[7:0])};
  endfunction

  function automatic logic [15:0] shift_rows(input logic [15:0] x);
    return {x[15:12], x[3:0], x[7:4], x[11:8]};
  endfunction

  function automatic logic [15:0] mix_cols(input logic [15:0] x);
    logic [15:0] r;
    for (int c = 0; c < 2; c++) begin
      logic [3:0] a, b;
      a = x[15-8*c -: 4];
      b = x[11-8*c -: 4];
      r[15-8*c -: 4] = a ^ gmul(4'h4, b);
      r[11-8*c -: 4] = gmul(4'h4, a) ^ b;
    end
    return r;
  endfunction

  function automatic logic [15:0] ref_enc(input logic [15:0] p, input logic [15:0] k);
    logic [7:0]  w [6];
    logic [15:0] st;
    w[0] = k[15:8];
    w[1] = k[7:0];
    w[2] = w[0] ^ 8'h80 ^ sub8({w[1][3:0], w[1][7:4]});
    w[3] = w[2] ^ w[1];
    w[4] = w[2] ^ 8'h30 ^ sub8({w[3][3:0], w[3][7:4]});
    w[5] = w[4] ^ w[3];
    st = p ^ {w[0], w[1]};
    st = mix_cols(shift_rows(sub16(st))) ^ {w[2], w[3]};
    st = shift_rows(sub16(st)) ^ {w[4], w[5]};
    return st;
  endfunction

  // Drives one transaction; holds out_ready low for 'stalls' cycles of DONE.
  task automatic run_txn(input logic [15:0] c, input logic [15:0] k, input int stalls,
                         input bit junk, output logic [15:0] got, output int lat,
                         output bit held_ok, output bit timeout);
    int n;
    timeout = 1'b0;
    held_ok = 1'b1;
    got     = 16'h0;
    lat     = 0;
    n       = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!in_ready) begin timeout = 1'b1; return; end
    in_valid  = 1'b1;
    cipher_in = c;
    key_in    = k;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid  = junk;
    cipher_in = 16'($urandom);
    key_in    = 16'($urandom);
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (junk) begin
        cipher_in = 16'($urandom);
        key_in    = 16'($urandom);
        if (in_ready) held_ok = 1'b0;
      end
    end
    if (!out_valid) begin timeout = 1'b1; in_valid = 1'b0; return; end
    got = plain_out;
    for (int i = 0; i < stalls; i++) begin
      @(posedge clk); #1;
      if (!out_valid || plain_out !== got || in_ready) held_ok = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; cipher_in = '0; key_in = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (plain_out !== 16'h0) begin errors++; $display("FAIL reset_plain_out: got %h expected 0000", plain_out); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_vector(input string nm, input logic [15:0] c, input logic [15:0] k,
                             input logic [15:0] exp, input int stalls);
    logic [15:0] got; int lat; bit held, to;
    run_txn(c, k, stalls, 1'b0, got, lat, held, to);
    checks++; if (to) begin errors++; $display("FAIL %s_timeout: handshake did not complete", nm); end
    checks++; if (got !== exp) begin errors++; $display("FAIL %s_data: got %h expected %h", nm, got, exp); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL %s_latency: got %0d expected 4", nm, lat); end
    checks++; if (!held) begin errors++; $display("FAIL %s_hold: output not stable during stall", nm); end
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || plain_out !== 16'h0) begin
      errors++; $display("FAIL %s_exit: got rdy=%b vld=%b busy=%b out=%h expected 1 0 0 0000",
                         nm, in_ready, out_valid, busy, plain_out);
    end
  endtask

  task automatic test_ignore_busy();
    logic [15:0] got; int lat; bit held, to;
    run_txn(16'h0738, 16'hA73B, 2, 1'b1, got, lat, held, to);
    checks++; if (to) begin errors++; $display("FAIL busy_timeout: handshake did not complete"); end
    checks++; if (got !== 16'h6F6B) begin errors++; $display("FAIL busy_data: got %h expected 6f6b", got); end
    checks++; if (!held) begin errors++; $display("FAIL busy_ready: in_ready rose or output moved while busy"); end
    // in_valid was high on the DONE exit edge; that edge must not accept.
    checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL busy_done_accept: got busy=%b rdy=%b expected 0 1", busy, in_ready);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL busy_idle: got rdy=%b expected 1", in_ready); end
  endtask

  task automatic abort_after(input int edges, input string nm);
    in_valid = 1'b1; cipher_in = 16'h0738; key_in = 16'hA73B; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (edges) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || plain_out !== 16'h0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL %s: got vld=%b busy=%b out=%h rdy=%b expected 0 0 0000 1",
                         nm, out_valid, busy, plain_out, in_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midflight();
    abort_after(2, "rst_rnd1");
    abort_after(4, "rst_done");
    test_vector("rst_fresh", 16'h0738, 16'hA73B, 16'h6F6B, 0);
  endtask

  task automatic test_random();
    logic [15:0] p, k, got; int lat; bit held, to;
    int bad = 0;
    for (int i = 0; i < 1000; i++) begin
      p = 16'($urandom);
      k = 16'($urandom);
      run_txn(ref_enc(p, k), k, $urandom_range(3, 0), 1'b0, got, lat, held, to);
      checks++;
      if (to || got !== p || !held || lat !== 4) begin
        errors++; bad++;
        if (bad <= 10)
          $display("FAIL rand_%0d: key=%h got %h expected %h lat=%0d held=%b to=%b", i, k, got, p, lat, held, to);
      end
      if (to) break;
    end
  endtask

  initial begin
    test_reset();
    test_vector("vec1", 16'h0738, 16'hA73B, 16'h6F6B, 0);
    test_vector("vec2", 16'h24EC, 16'h4AF5, 16'hD728, 0);
    test_vector("stall", 16'h0738, 16'hA73B, 16'h6F6B, 10);
    test_ignore_busy();
    test_reset_midflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
